pc_stack_unit: RTL

//  Parametrised program counter with hardware call/return stack for the multi-cycle CPU.

---
 rtl/pc_stack_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware call/return stack, PC-relative branches and
// a stall enable. Sticky flags record calls on a full stack and returns on an empty one.
module pc_stack_unit #(
  parameter int ADDR_W    = 6,
  parameter int OFF_W     = 4,
  parameter int DEPTH     = 4,
  parameter int RESET_VEC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr_pc,
  input  logic                       ret_pc,
  input  logic                       call_pc,
  input  logic                       ld_pc,
  input  logic                       br_pc,
  input  logic                       inc_pc,
  input  logic                       err_clr,
  input  logic [ADDR_W-1:0]          target,
  input  logic [OFF_W-1:0]           offset,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(DEPTH+1)-1:0] sp_out,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [SP_W-1:0]   SP_MAX = SP_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [DEPTH];

  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] pc_br_s;
  logic [ADDR_W-1:0] off_ext_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              push_s;
  logic              full_s;
  logic              empty_s;

  // Datapath helpers: increment, sign-extended branch target, stack pointers.
  assign pc_inc_s  = pc_q + ADDR_W'(1);
  assign off_ext_s = ADDR_W'($signed(offset));
  assign pc_br_s   = pc_q + off_ext_s;
  assign wr_idx_s  = IDX_W'(sp_q);
  assign rd_idx_s  = IDX_W'(sp_q - SP_W'(1));
  assign full_s    = (sp_q == SP_MAX);
  assign empty_s   = (sp_q == SP_W'(0));

  // Next-state selection following the strobe priority order.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push_s = 1'b0;

    // Error clear is evaluated first so that a flag set below in the same cycle wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end

    if (clr_pc) begin
      pc_d = RST_PC;
      sp_d = SP_W'(0);
    end else if (!en) begin
      pc_d = pc_q;
    end else if (ret_pc) begin
      if (!empty_s) begin
        pc_d = stack_q[rd_idx_s];
        sp_d = sp_q - SP_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call_pc) begin
      if (!full_s) begin
        push_s = 1'b1;
        pc_d   = target;
        sp_d   = sp_q + SP_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ld_pc) begin
      pc_d = target;
    end else if (br_pc) begin
      pc_d = pc_br_s;
    end else if (inc_pc) begin
      pc_d = pc_inc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RST_PC;
      sp_q  <= SP_W'(0);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address storage; contents only become visible through a valid pop.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[wr_idx_s] <= pc_inc_s;
    end
  end

  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign stk_full  = full_s;
  assign stk_empty = empty_s;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule
